instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Upstream neighbour of the 32-entry instruction ROM.
- Owns the program counter and drives the ROM address; the ROM read is combinational.
- Captures the returned word into an instruction register and hands it to the decoder over a valid/ready handshake.
- Handles jumps (flush + redirect), decoder backpressure and start/stop control.

Parameters:
- ADDR_WIDTH, 5, PC/ROM address width; the address space is 2**ADDR_WIDTH words.
- IW, `INSTRUCTION_WIDTH (6), instruction word width.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- fetch_en  in  1  level; 1 = fetching permitted.
- rom_addr  out  ADDR_WIDTH  address to the ROM; always equals the pc register.
- rom_data  in  IW  ROM read data, combinational from rom_addr.
- instr  out  IW  registered instruction to the decoder.
- instr_pc  out  ADDR_WIDTH  address that instr was fetched from.
- instr_valid  out  1  instr holds an unconsumed instruction.
- instr_ready  in  1  decoder accepts instr in this cycle.
- jump_en  in  1  single-cycle redirect request.
- jump_addr  in  ADDR_WIDTH  redirect target.
- halted  out  1  fetch stopped at end of memory; only driven with the optional feature, otherwise tied 0.

Behaviour:
- Reset (rst_n=0, asynchronous, takes effect immediately): pc=RESET_PC, instr=0, instr_pc=0, instr_valid=0, halted=0, state=IDLE. Reset mid-operation discards any held instruction.
- States:
  - IDLE: no fetch. IDLE->RUN when fetch_en=1.
  - RUN: fetching. RUN->IDLE when fetch_en=0.
  - HALTED: only with the optional feature.
- Slot free: (!instr_valid || instr_ready).
- Fetch in RUN, when the slot is free and jump_en=0:
  - instr<=rom_data, instr_pc<=pc, instr_valid<=1.
  - pc<=pc+1 modulo 2**ADDR_WIDTH, so 31 wraps to 0.
- Latency: one cycle from pc to instr. With instr_ready held high, one instruction per cycle.
- Consume without refill (slot free but no fetch in this cycle): instr_valid<=0 when instr_ready=1; instr and instr_pc keep their old values.
- Backpressure (instr_valid=1, instr_ready=0): instr, instr_pc, instr_valid and pc all hold.
- Jump (jump_en=1, any state, highest priority):
  - pc<=jump_addr and instr_valid<=0, killing the held instruction even when instr_ready=0.
  - The state is unchanged, except HALTED->RUN.
  - Causes exactly one bubble cycle; the first post-jump instruction has instr_pc=jump_addr.
- fetch_en=0 while an instruction is held: it stays valid until consumed, and no new fetch starts.
- jump_en and fetch_en rising in the same cycle: the jump applies, the state moves to RUN, and the first fetch comes from jump_addr on the next cycle.
- rom_addr is never X after reset.

Optional Feature:
- Macro: FETCH_HALT_ON_WRAP_EN.
- Defined:
  - When the fetch of address 2**ADDR_WIDTH-1 occurs, pc does not wrap. The state goes to HALTED and halted<=1 on the same edge.
  - HALTED: no fetches. The last instruction remains valid until consumed.
  - jump_en leaves HALTED for RUN and clears halted. Reset also clears it.
- Undefined: pc wraps 31->0, there is no HALTED state, and halted is constant 0.

Decomposition:
- Shared include (the opcode header):
  - `INSTRUCTION_WIDTH.
  - State encodings FETCH_IDLE, FETCH_RUN, FETCH_HALTED.
  - Default ADDR_WIDTH constant.
- One sub-module, program_counter: holds pc, with load (jump), increment (with wrap/saturate control) and async active-low reset.
- The FSM and instruction register stay in instr_fetch_unit.

Test Plan:
1. Reset, fetch_en=1, instr_ready=1 → instr_valid rises 1 cycle later; instr_pc sequence 0,1,2,3; instr equals ROM[0..3] (ROM[0]=ASM(ADD,R3), ROM[1]=6'b000010).
2. Backpressure: instr_ready=0 for 3 cycles while instr_pc=4 → instr, instr_pc=4 and rom_addr=5 are stable. On release, next instr_pc=5.
3. Jump: jump_en=1, jump_addr=20 while instr_valid=1 and instr_ready=0 → next cycle instr_valid=0 (one bubble); then instr_pc=20, 21 with ROM[20]=6'b010101.
4. Wrap (macro off): run from jump_addr=30 → instr_pc 30, 31, 0, 1; halted stays 0.
5. Macro on: run to 31 → halted=1 after the fetch of 31. Instr 31 stays valid until consumed, then instr_valid=0 with no further fetches. jump_en with addr 2 → halted=0 and instr_pc=2 after one bubble.
6. Assert rst_n=0 between clock edges mid-run → instr_valid=0, rom_addr=RESET_PC and halted=0 immediately. Deassert with fetch_en=1 → restart from address 0.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// Shared opcode header for the fetch unit: instruction width, default address width, FSM encodings.
// Optional feature macro: FETCH_HALT_ON_WRAP_EN (stop fetching after the last address instead of wrapping).
`ifndef INSTRUCTION_WIDTH
`define INSTRUCTION_WIDTH 6
`endif

package instr_fetch_unit_pkg;

   localparam int DEFAULT_ADDR_WIDTH = 5;

   typedef enum logic [1:0] {
      FETCH_IDLE   = 2'd0,
      FETCH_RUN    = 2'd1,
      FETCH_HALTED = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch bus: ROM address/data pair plus the instruction valid/ready handshake towards the decoder.
interface instr_fetch_unit_if
   import instr_fetch_unit_pkg::*;
#(
   parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
   parameter int IW         = `INSTRUCTION_WIDTH
);

   logic [ADDR_WIDTH-1:0] rom_addr;
   logic [IW-1:0]         rom_data;
   logic [IW-1:0]         instr;
   logic [ADDR_WIDTH-1:0] instr_pc;
   logic                  instr_valid;
   logic                  instr_ready;

   modport master (
      output rom_addr, instr, instr_pc, instr_valid,
      input  rom_data, instr_ready
   );

   modport slave (
      input  rom_addr, instr, instr_pc, instr_valid,
      output rom_data, instr_ready
   );

endinterface

// File: rtl/instr_fetch_unit_program_counter.sv
// Program counter: jump load beats increment; increment either wraps or saturates at the top address.
module program_counter
   import instr_fetch_unit_pkg::*;
#(
   parameter int          ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
   parameter int unsigned RESET_PC   = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load_en,
   input  logic [ADDR_WIDTH-1:0] load_addr,
   input  logic                  inc_en,
   input  logic                  wrap_en,
   output logic [ADDR_WIDTH-1:0] pc
);

   logic [ADDR_WIDTH-1:0] pc_q;
   logic [ADDR_WIDTH-1:0] pc_d;

   always_comb begin
      pc_d = pc_q;
      if (load_en) begin
         pc_d = load_addr;
      end else if (inc_en && (wrap_en || (pc_q != '1))) begin
         pc_d = pc_q + ADDR_WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q <= ADDR_WIDTH'(RESET_PC);
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, registers ROM words and hands them to the decoder over valid/ready.
// Optional feature macro: FETCH_HALT_ON_WRAP_EN.
module instr_fetch_unit
   import instr_fetch_unit_pkg::*;
#(
   parameter int          ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
   parameter int          IW         = `INSTRUCTION_WIDTH,
   parameter int unsigned RESET_PC   = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  fetch_en,
   input  logic                  jump_en,
   input  logic [ADDR_WIDTH-1:0] jump_addr,
   output logic                  halted,
   instr_fetch_unit_if.master    bus
);

   fetch_state_e          state_q, state_d;
   logic [IW-1:0]         instr_q, instr_d;
   logic [ADDR_WIDTH-1:0] instr_pc_q, instr_pc_d;
   logic                  instr_valid_q, instr_valid_d;
   logic [ADDR_WIDTH-1:0] pc;
   logic                  slot_free;
   logic                  do_fetch;
   logic                  wrap_en;
`ifdef FETCH_HALT_ON_WRAP_EN
   logic                  halted_q, halted_d;
`endif

   program_counter #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .RESET_PC   (RESET_PC)
   ) u_pc (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_en   (jump_en),
      .load_addr (jump_addr),
      .inc_en    (do_fetch),
      .wrap_en   (wrap_en),
      .pc        (pc)
   );

   // Jump outranks fetch, which outranks a plain consume; the jump also kills a stalled instruction.
   always_comb begin
      state_d       = state_q;
      instr_d       = instr_q;
      instr_pc_d    = instr_pc_q;
      instr_valid_d = instr_valid_q;
      wrap_en       = 1'b1;
`ifdef FETCH_HALT_ON_WRAP_EN
      halted_d      = halted_q;
`endif
      slot_free = !instr_valid_q || bus.instr_ready;
      do_fetch  = (state_q == FETCH_RUN) && fetch_en && slot_free && !jump_en;

      case (state_q)
         FETCH_IDLE: if (fetch_en)  state_d = FETCH_RUN;
         FETCH_RUN:  if (!fetch_en) state_d = FETCH_IDLE;
         default:    state_d = state_q;
      endcase

      if (jump_en) begin
         instr_valid_d = 1'b0;
`ifdef FETCH_HALT_ON_WRAP_EN
         halted_d = 1'b0;
         if (state_q == FETCH_HALTED) state_d = FETCH_RUN;
`endif
      end else if (do_fetch) begin
         instr_d       = bus.rom_data;
         instr_pc_d    = pc;
         instr_valid_d = 1'b1;
`ifdef FETCH_HALT_ON_WRAP_EN
         wrap_en = 1'b0;
         if (pc == '1) begin
            state_d  = FETCH_HALTED;
            halted_d = 1'b1;
         end
`endif
      end else if (bus.instr_ready) begin
         instr_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= FETCH_IDLE;
         instr_q       <= '0;
         instr_pc_q    <= '0;
         instr_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         instr_q       <= instr_d;
         instr_pc_q    <= instr_pc_d;
         instr_valid_q <= instr_valid_d;
      end
   end

`ifdef FETCH_HALT_ON_WRAP_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         halted_q <= 1'b0;
      end else begin
         halted_q <= halted_d;
      end
   end

   assign halted = halted_q;
`else
   assign halted = 1'b0;
`endif

   assign bus.rom_addr    = pc;
   assign bus.instr       = instr_q;
   assign bus.instr_pc    = instr_pc_q;
   assign bus.instr_valid = instr_valid_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: fetch stream, backpressure, jumps, wrap or halt, async reset.
module tb_instr_fetch_unit;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] REG_R3 = 3'd3;

   logic       clk;
   logic       rst_n;
   logic       fetch_en;
   logic       jump_en;
   logic [4:0] jump_addr;
   logic       halted;
   logic [5:0] rom [0:31];

   int assertCount;
   int failCount;

   instr_fetch_unit_if #(.ADDR_WIDTH(5), .IW(6)) bus ();

   instr_fetch_unit #(
      .ADDR_WIDTH (5),
      .IW         (6),
      .RESET_PC   (0)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .fetch_en  (fetch_en),
      .jump_en   (jump_en),
      .jump_addr (jump_addr),
      .halted    (halted),
      .bus       (bus)
   );

   assign bus.rom_data = rom[bus.rom_addr];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [5:0] asmWord(input logic [2:0] op, input logic [2:0] rd);
      return {op, rd};
   endfunction

   // Drive one cycle of inputs, then land 1 time unit after the rising edge to observe its effect.
   task automatic applyStimulus(input logic fe, input logic rdy, input logic je, input logic [4:0] ja);
      fetch_en        = fe;
      bus.instr_ready = rdy;
      jump_en         = je;
      jump_addr       = ja;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
      end
   endtask

   initial begin
      assertCount = 0;
      failCount   = 0;
      for (int i = 0; i < 32; i++) rom[i] = 6'(i) ^ 6'h2A;
      rom[0]  = asmWord(OP_ADD, REG_R3);
      rom[1]  = 6'b000010;
      rom[20] = 6'b010101;

      rst_n           = 1'b0;
      fetch_en        = 1'b0;
      jump_en         = 1'b0;
      jump_addr       = 5'd0;
      bus.instr_ready = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_valid", 32'(bus.instr_valid), 32'd0);
      checkOutput("reset_rom_addr", 32'(bus.rom_addr), 32'd0);
      checkOutput("reset_instr", 32'(bus.instr), 32'd0);
      checkOutput("reset_instr_pc", 32'(bus.instr_pc), 32'd0);
      checkOutput("reset_halted", 32'(halted), 32'd0);
      rst_n = 1'b1;

      $display("[TB] test 1: basic fetch stream");
      applyStimulus(1'b1, 1'b1, 1'b0, 5'd0);
      checkOutput("idle_to_run_valid", 32'(bus.instr_valid), 32'd0);
      for (int k = 0; k < 4; k++) begin
         applyStimulus(1'b1, 1'b1, 1'b0, 5'd0);
         checkOutput("stream_valid", 32'(bus.instr_valid), 32'd1);
         checkOutput("stream_pc", 32'(bus.instr_pc), 32'(k));
         checkOutput("stream_instr", 32'(bus.instr), 32'(rom[k]));
      end
      checkOutput("rom0_is_add_r3", 32'(rom[0]), 32'h03);

      $display("[TB] test 2: backpressure");
      applyStimulus(1'b1, 1'b1, 1'b0, 5'd0);
      checkOutput("bp_pc_before", 32'(bus.instr_pc), 32'd4);
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 5'd0);
         checkOutput("bp_valid", 32'(bus.instr_valid), 32'd1);
         checkOutput("bp_instr_pc", 32'(bus.instr_pc), 32'd4);
         checkOutput("bp_instr", 32'(bus.instr), 32'(rom[4]));
         checkOutput("bp_rom_addr", 32'(bus.rom_addr), 32'd5);
      end
      applyStimulus(1'b1, 1'b1, 1'b0, 5'd0);
      checkOutput("bp_release_pc", 32'(bus.instr_pc), 32'd5);

      $display("[TB] test 3: jump while stalled");
      applyStimulus(1'b1, 1'b0, 1'b1, 5'd20);
      checkOutput("jump_bubble", 32'(bus.instr_valid), 32'd0);
      checkOutput("jump_rom_addr", 32'(bus.rom_addr), 32'd20);
      applyStimulus(1'b1, 1'b1, 1'b0, 5'd0);
      checkOutput("jump_first_pc", 32'(bus.instr_pc), 32'd20);
      checkOutput("jump_first_instr", 32'(bus.instr), 32'h15);
      checkOutput("jump_first_valid", 32'(bus.instr_valid), 32'd1);
      applyStimulus(1'b1, 1'b1, 1'b0, 5'd0);
      checkOutput("jump_second_pc", 32'(bus.instr_pc), 32'd21);

      applyStimulus(1'b1, 1'b1, 1'b1, 5'd30);
      checkOutput("jump30_bubble", 32'(bus.instr_valid), 32'd0);
`ifdef FETCH_HALT_ON_WRAP_EN
      $display("[TB] test 5: halt at end of memory");
      applyStimulus(1'b1, 1'b1, 1'b0, 5'd0);
      checkOutput("halt_pc30", 32'(bus.instr_pc), 32'd30);
      checkOutput("halt_not_yet", 32'(halted), 32'd0);
      applyStimulus(1'b1, 1'b1, 1'b0, 5'd0);
      checkOutput("halt_pc31", 32'(bus.instr_pc), 32'd31);
      checkOutput("halt_set", 32'(halted), 32'd1);
      applyStimulus(1'b1, 1'b0, 1'b0, 5'd0);
      checkOutput("halt_held_valid", 32'(bus.instr_valid), 32'd1);
      checkOutput("halt_held_pc", 32'(bus.instr_pc), 32'd31);
      applyStimulus(1'b1, 1'b1, 1'b0, 5'd0);
      checkOutput("halt_consumed", 32'(bus.instr_valid), 32'd0);
      applyStimulus(1'b1, 1'b1, 1'b0, 5'd0);
      checkOutput("halt_no_fetch", 32'(bus.instr_valid), 32'd0);
      checkOutput("halt_rom_addr", 32'(bus.rom_addr), 32'd31);
      applyStimulus(1'b1, 1'b1, 1'b1, 5'd2);
      checkOutput("halt_cleared", 32'(halted), 32'd0);
      checkOutput("halt_jump_bubble", 32'(bus.instr_valid), 32'd0);
      applyStimulus(1'b1, 1'b1, 1'b0, 5'd0);
      checkOutput("halt_resume_pc", 32'(bus.instr_pc), 32'd2);
      checkOutput("halt_resume_valid", 32'(bus.instr_valid), 32'd1);
`else
      $display("[TB] test 4: wrap-around");
      for (int k = 0; k < 4; k++) begin
         applyStimulus(1'b1, 1'b1, 1'b0, 5'd0);
         checkOutput("wrap_pc", 32'(bus.instr_pc), 32'((30 + k) % 32));
         checkOutput("wrap_halted", 32'(halted), 32'd0);
      end
`endif

      $display("[TB] test 6: asynchronous reset mid-run");
      checkOutput("pre_reset_valid", 32'(bus.instr_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async_reset_valid", 32'(bus.instr_valid), 32'd0);
      checkOutput("async_reset_rom_addr", 32'(bus.rom_addr), 32'd0);
      checkOutput("async_reset_halted", 32'(halted), 32'd0);
      #1;
      rst_n = 1'b1;
      applyStimulus(1'b1, 1'b1, 1'b0, 5'd0);
      checkOutput("restart_idle_valid", 32'(bus.instr_valid), 32'd0);
      applyStimulus(1'b1, 1'b1, 1'b0, 5'd0);
      checkOutput("restart_pc", 32'(bus.instr_pc), 32'd0);
      checkOutput("restart_instr", 32'(bus.instr), 32'(rom[0]));

      $display("[TB] fetch_en drop with held instruction, then jump with fetch_en");
      applyStimulus(1'b0, 1'b0, 1'b0, 5'd0);
      checkOutput("stop_held_valid", 32'(bus.instr_valid), 32'd1);
      checkOutput("stop_held_pc", 32'(bus.instr_pc), 32'd0);
      applyStimulus(1'b0, 1'b1, 1'b0, 5'd0);
      checkOutput("stop_consumed", 32'(bus.instr_valid), 32'd0);
      checkOutput("stop_rom_addr", 32'(bus.rom_addr), 32'd1);
      applyStimulus(1'b0, 1'b1, 1'b0, 5'd0);
      checkOutput("stop_no_fetch", 32'(bus.instr_valid), 32'd0);
      applyStimulus(1'b1, 1'b1, 1'b1, 5'd10);
      checkOutput("jump_start_bubble", 32'(bus.instr_valid), 32'd0);
      checkOutput("jump_start_rom_addr", 32'(bus.rom_addr), 32'd10);
      applyStimulus(1'b1, 1'b1, 1'b0, 5'd0);
      checkOutput("jump_start_pc", 32'(bus.instr_pc), 32'd10);
      checkOutput("jump_start_instr", 32'(bus.instr), 32'(rom[10]));

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
